// File: rtl/cpm_disk_pkg.sv
// ============================================================
// cpm_disk_pkg - shared constants for the CP/M disk controller
// Rev 1.0
// ============================================================
`default_nettype none

package cpm_disk_pkg;

  localparam logic [2:0] OFF_DRIVE  = 3'd0;
  localparam logic [2:0] OFF_TRK_LO = 3'd1;
  localparam logic [2:0] OFF_TRK_HI = 3'd2;
  localparam logic [2:0] OFF_SECTOR = 3'd3;
  localparam logic [2:0] OFF_DMA_LO = 3'd4;
  localparam logic [2:0] OFF_DMA_HI = 3'd5;
  localparam logic [2:0] OFF_CMD    = 3'd6;
  localparam logic [2:0] OFF_ERROR  = 3'd7;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [7:0] ERR_NONE    = 8'd0;
  localparam logic [7:0] ERR_GEOM    = 8'd1;
  localparam logic [7:0] ERR_SD      = 8'd2;
  localparam logic [7:0] ERR_TIMEOUT = 8'd3;
  localparam logic [7:0] ERR_BAD_CMD = 8'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_ERROR = 1;
  localparam int STAT_READY = 7;

  function automatic logic [7:0] status_byte(input logic busy, input logic err,
                                             input logic ready);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_BUSY]  = busy;
    s[STAT_ERROR] = err;
    s[STAT_READY] = ready;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpm_lba_calc.sv
// ============================================================
// cpm_lba_calc - 16-step shift-add track*SPT plus drive/sector LBA adder
// Rev 1.0
// ============================================================
`default_nettype none

module cpm_lba_calc #(
  parameter int unsigned SECTORS_PER_TRACK = 26,
  parameter int unsigned DRIVE_SHIFT       = 14
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_drive,
  input  logic [15:0] i_track,
  input  logic [7:0]  i_sector_off,
  output logic        o_done,
  output logic [25:0] o_lba
);

  logic        active_q;
  logic [3:0]  cnt_q;
  logic [15:0] mplier_q;
  logic [25:0] mcand_q;
  logic [25:0] acc_q;
  logic [25:0] acc_d;
  logic [7:0]  drive_q;
  logic [7:0]  soff_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : 26'd0);
  // Result is valid combinationally during the final step so the caller can register it on that edge.
  assign o_done = active_q && (cnt_q == 4'd15);
  assign o_lba  = (26'(drive_q) << DRIVE_SHIFT) + acc_d + 26'(soff_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
      mplier_q <= 16'd0;
      mcand_q  <= 26'd0;
      acc_q    <= 26'd0;
      drive_q  <= 8'd0;
      soff_q   <= 8'd0;
    end else if (i_start) begin
      active_q <= 1'b1;
      cnt_q    <= 4'd0;
      mplier_q <= i_track;
      mcand_q  <= 26'(SECTORS_PER_TRACK);
      acc_q    <= 26'd0;
      drive_q  <= i_drive;
      soff_q   <= i_sector_off;
    end else if (active_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) active_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpm_disk_ctrl.sv
// ============================================================
// cpm_disk_ctrl - CP/M disk I/O register file and SD request sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module cpm_disk_ctrl
  import cpm_disk_pkg::*;
#(
  parameter logic [7:0]  BASE_PORT         = 8'h10,
  parameter int unsigned SECTORS_PER_TRACK = 26,
  parameter int unsigned TRACKS_PER_DISK   = 77,
  parameter int unsigned SECTOR_BASE       = 1,
  parameter int unsigned DRIVE_SHIFT       = 14,
  parameter int unsigned NUM_DRIVES        = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 27_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_io_addr,
  input  logic        i_io_wr,
  input  logic        i_io_rd,
  input  logic [7:0]  i_io_data,
  output logic [7:0]  o_io_data,
  output logic        o_io_sel,
  input  logic        i_disk_ready,
  input  logic [3:0]  i_sd_error,
  output logic        o_disk_read,
  output logic        o_disk_write,
  output logic [23:0] o_disk_block_address,
  output logic [1:0]  o_disk_block_sub_address,
  output logic [15:0] o_dma_start_address,
  output logic        o_busy
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  drive_q, drive_d;
  logic [15:0] track_q, track_d;
  logic [7:0]  sector_q, sector_d;
  logic [15:0] dma_q, dma_d;
  logic [7:0]  err_q, err_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] tmo_q, tmo_d;
  logic [23:0] blk_q, blk_d;
  logic [1:0]  sub_q, sub_d;
  logic [15:0] dma_out_q, dma_out_d;

  logic [7:0]  io_off_full;
  logic [2:0]  io_off;
  logic        in_range;
  logic        wr_hit;
  logic        busy;
  logic        geom_bad;
  logic        calc_start;
  logic        calc_done;
  logic [25:0] calc_lba;
  logic [7:0]  sector_off;

  // Wrapping subtraction makes the window test correct for any BASE_PORT.
  assign io_off_full = i_io_addr - BASE_PORT;
  assign in_range    = (io_off_full[7:3] == 5'd0);
  assign io_off      = io_off_full[2:0];
  assign wr_hit      = i_io_wr && in_range;
  assign busy        = (state_q != S_IDLE);
  assign sector_off  = sector_q - 8'(SECTOR_BASE);

  assign geom_bad = (32'(drive_q) >= NUM_DRIVES)
                 || (32'(track_q) >= TRACKS_PER_DISK)
                 || (32'(sector_q) < SECTOR_BASE)
                 || ((32'(sector_q) - SECTOR_BASE) >= SECTORS_PER_TRACK);

  assign o_io_sel                 = i_io_rd && in_range;
  assign o_busy                   = busy;
  assign o_disk_read              = (state_q == S_REQ) && !op_wr_q;
  assign o_disk_write             = (state_q == S_REQ) && op_wr_q;
  assign o_disk_block_address     = blk_q;
  assign o_disk_block_sub_address = sub_q;
  assign o_dma_start_address      = dma_out_q;

  always_comb begin
    o_io_data = 8'hFF;
    if (in_range) begin
      case (io_off)
        OFF_DRIVE:  o_io_data = drive_q;
        OFF_TRK_LO: o_io_data = track_q[7:0];
        OFF_TRK_HI: o_io_data = track_q[15:8];
        OFF_SECTOR: o_io_data = sector_q;
        OFF_DMA_LO: o_io_data = dma_q[7:0];
        OFF_DMA_HI: o_io_data = dma_q[15:8];
        OFF_CMD:    o_io_data = status_byte(busy, err_q != ERR_NONE, i_disk_ready);
        default:    o_io_data = err_q;
      endcase
    end
  end

  cpm_lba_calc #(
    .SECTORS_PER_TRACK (SECTORS_PER_TRACK),
    .DRIVE_SHIFT       (DRIVE_SHIFT)
  ) u_lba_calc (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (calc_start),
    .i_drive      (drive_q),
    .i_track      (track_q),
    .i_sector_off (sector_off),
    .o_done       (calc_done),
    .o_lba        (calc_lba)
  );

  always_comb begin
    state_d    = state_q;
    drive_d    = drive_q;
    track_d    = track_q;
    sector_d   = sector_q;
    dma_d      = dma_q;
    err_d      = err_q;
    op_wr_d    = op_wr_q;
    tmo_d      = tmo_q;
    blk_d      = blk_q;
    sub_d      = sub_q;
    dma_out_d  = dma_out_q;
    calc_start = 1'b0;

    if (wr_hit && !busy) begin
      case (io_off)
        OFF_DRIVE:  drive_d        = i_io_data;
        OFF_TRK_LO: track_d[7:0]   = i_io_data;
        OFF_TRK_HI: track_d[15:8]  = i_io_data;
        OFF_SECTOR: sector_d       = i_io_data;
        OFF_DMA_LO: dma_d[7:0]     = i_io_data;
        OFF_DMA_HI: dma_d[15:8]    = i_io_data;
        OFF_CMD: begin
          if ((i_io_data == CMD_READ) || (i_io_data == CMD_WRITE)) begin
            err_d = ERR_NONE;
            if (geom_bad) begin
              err_d = ERR_GEOM;
            end else begin
              op_wr_d    = (i_io_data == CMD_WRITE);
              calc_start = 1'b1;
              state_d    = S_CALC;
            end
          end else begin
            err_d = ERR_BAD_CMD;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_CALC: begin
        if (calc_done) begin
          blk_d     = calc_lba[25:2];
          sub_d     = calc_lba[1:0];
          dma_out_d = dma_q;
          tmo_d     = 32'd0;
          state_d   = S_REQ;
        end
      end
      S_REQ, S_RUN: begin
        if (i_sd_error != 4'd0) begin
          err_d   = ERR_SD;
          state_d = S_IDLE;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if ((state_q == S_REQ) && !i_disk_ready) state_d = S_RUN;
          if ((state_q == S_RUN) && i_disk_ready)  state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      drive_q   <= 8'd0;
      track_q   <= 16'd0;
      sector_q  <= 8'd0;
      dma_q     <= 16'd0;
      err_q     <= ERR_NONE;
      op_wr_q   <= 1'b0;
      tmo_q     <= 32'd0;
      blk_q     <= 24'd0;
      sub_q     <= 2'd0;
      dma_out_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      drive_q   <= drive_d;
      track_q   <= track_d;
      sector_q  <= sector_d;
      dma_q     <= dma_d;
      err_q     <= err_d;
      op_wr_q   <= op_wr_d;
      tmo_q     <= tmo_d;
      blk_q     <= blk_d;
      sub_q     <= sub_d;
      dma_out_q <= dma_out_d;
    end
  end

endmodule

`default_nettype wire
